// File: rtl/vt52_cursor_ctrl.sv
// rtl/vt52_cursor_ctrl.sv - VT52 byte-stream decoder driving cursor row/col registers and the character writer
// Shadow row/col are the only cursor state; the external registers just mirror them.
module vt52_cursor_ctrl #(
  parameter int COLS     = 80,
  parameter int ROWS     = 24,
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                char_valid,
  input  logic [7:0]          char_data,
  output logic                char_ready,
  output logic                col_wen,
  output logic [COL_BITS-1:0] col_wdata,
  output logic                row_wen,
  output logic [ROW_BITS-1:0] row_wdata,
  output logic                print_valid,
  output logic [7:0]          print_char,
  input  logic                print_ready,
  output logic                scroll_req,
  output logic                clr_eol,
  output logic                clr_eos
);

  typedef enum logic [2:0] {IDLE, ESC, YROW, YCOL, PRINT_WAIT} state_t;

  localparam logic [COL_BITS-1:0] COL_MAX   = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX   = ROW_BITS'(ROWS - 1);
  localparam logic [7:0]          ROWS_B    = 8'(ROWS);
  localparam logic [7:0]          COL_MAX_B = 8'(COLS - 1);

  state_t              state, state_n;
  logic [COL_BITS-1:0] col, col_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic                col_wen_n, row_wen_n, scroll_n, eol_n, eos_n;
  logic                print_valid_n;
  logic [7:0]          print_char_n;

  logic                accept;
  logic [7:0]          yv;
  logic [COL_BITS:0]   tab_sum;
  logic [COL_BITS-1:0] tab_col, col_inc, col_dec;
  logic [ROW_BITS-1:0] row_inc, row_dec;

  assign char_ready = (state != PRINT_WAIT);
  assign accept     = char_valid && char_ready;
  assign col_wdata  = col;
  assign row_wdata  = row;

  // Saturating neighbours of the shadows, shared by several commands
  assign yv      = char_data - 8'h20;
  assign tab_sum = {1'b0, col | COL_BITS'(7)} + (COL_BITS + 1)'(1);
  assign tab_col = (tab_sum > {1'b0, COL_MAX}) ? COL_MAX : tab_sum[COL_BITS-1:0];
  assign col_inc = (col == COL_MAX) ? col : col + COL_BITS'(1);
  assign col_dec = (col == '0) ? col : col - COL_BITS'(1);
  assign row_inc = (row == ROW_MAX) ? row : row + ROW_BITS'(1);
  assign row_dec = (row == '0) ? row : row - ROW_BITS'(1);

  always_comb begin
    state_n       = state;
    col_n         = col;
    row_n         = row;
    col_wen_n     = 1'b0;
    row_wen_n     = 1'b0;
    scroll_n      = 1'b0;
    eol_n         = 1'b0;
    eos_n         = 1'b0;
    print_valid_n = print_valid;
    print_char_n  = print_char;
    case (state)
      IDLE: if (accept) begin
        case (char_data)
          8'h1B: state_n = ESC;
          8'h0D: begin col_n = '0; col_wen_n = 1'b1; end
          8'h0A: begin
            if (row != ROW_MAX) begin row_n = row_inc; row_wen_n = 1'b1; end
            else scroll_n = 1'b1;
          end
          8'h08: if (col != '0) begin col_n = col_dec; col_wen_n = 1'b1; end
          8'h09: begin col_n = tab_col; col_wen_n = 1'b1; end
          default: if (char_data >= 8'h20 && char_data <= 8'h7E) begin
            print_char_n  = char_data;
            print_valid_n = 1'b1;
            state_n       = PRINT_WAIT;
          end
        endcase
      end
      ESC: if (accept) begin
        state_n = IDLE;
        case (char_data)
          8'h41: begin row_n = row_dec; row_wen_n = (row != '0); end
          8'h42: begin row_n = row_inc; row_wen_n = (row != ROW_MAX); end
          8'h43: begin col_n = col_inc; col_wen_n = (col != COL_MAX); end
          8'h44: begin col_n = col_dec; col_wen_n = (col != '0); end
          8'h48: begin
            row_n = '0; col_n = '0; row_wen_n = 1'b1; col_wen_n = 1'b1;
          end
          8'h4A: eos_n = 1'b1;
          8'h4B: eol_n = 1'b1;
          8'h59: state_n = YROW;
          default: ;
        endcase
      end
      YROW: if (accept) begin
        if (yv < ROWS_B) begin row_n = yv[ROW_BITS-1:0]; row_wen_n = 1'b1; end
        state_n = YCOL;
      end
      YCOL: if (accept) begin
        col_n     = (yv > COL_MAX_B) ? COL_MAX : yv[COL_BITS-1:0];
        col_wen_n = 1'b1;
        state_n   = IDLE;
      end
      PRINT_WAIT: if (print_ready) begin
        // No autowrap: the last column re-strobes its own value
        print_valid_n = 1'b0;
        col_n         = col_inc;
        col_wen_n     = 1'b1;
        state_n       = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      col_wen     <= 1'b0;
      row_wen     <= 1'b0;
      scroll_req  <= 1'b0;
      clr_eol     <= 1'b0;
      clr_eos     <= 1'b0;
      print_valid <= 1'b0;
      print_char  <= 8'h00;
    end else begin
      state       <= state_n;
      col         <= col_n;
      row         <= row_n;
      col_wen     <= col_wen_n;
      row_wen     <= row_wen_n;
      scroll_req  <= scroll_n;
      clr_eol     <= eol_n;
      clr_eos     <= eos_n;
      print_valid <= print_valid_n;
      print_char  <= print_char_n;
    end
  end

endmodule

// File: tb/tb_vt52_cursor_ctrl.sv
// tb/tb_vt52_cursor_ctrl.sv - directed and randomized bench against a behavioural VT52 cursor model
module tb_vt52_cursor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       col_wen, row_wen, print_valid, print_ready = 1'b0;
  logic [6:0] col_wdata;
  logic [4:0] row_wdata;
  logic [7:0] print_char;
  logic       scroll_req, clr_eol, clr_eos;

  vt52_cursor_ctrl dut (
    .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .col_wen(col_wen), .col_wdata(col_wdata),
    .row_wen(row_wen), .row_wdata(row_wdata), .print_valid(print_valid),
    .print_char(print_char), .print_ready(print_ready), .scroll_req(scroll_req),
    .clr_eol(clr_eol), .clr_eos(clr_eos)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural cursor model: mode is where we are in a VT52 sequence
  localparam int M_IDLE = 0, M_ESC = 1, M_YROW = 2, M_YCOL = 3, M_PRINT = 4;
  int m_mode, m_row, m_col, m_pc;
  bit m_pv, m_cwen, m_rwen, m_scr, m_eol, m_eos;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_row = 0; m_col = 0; m_pc = 0; m_pv = 0;
    m_cwen = 0; m_rwen = 0; m_scr = 0; m_eol = 0; m_eos = 0;
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit rst, input bit v, input int d, input bit pr);
    int y;
    if (rst) begin model_reset(); return; end
    m_cwen = 0; m_rwen = 0; m_scr = 0; m_eol = 0; m_eos = 0;
    y = (d - 32) & 255;
    if (m_mode == M_PRINT) begin
      if (pr) begin m_pv = 0; m_col = min_i(m_col + 1, 79); m_cwen = 1; m_mode = M_IDLE; end
    end else if (v) begin
      case (m_mode)
        M_IDLE: begin
          if (d == 27) m_mode = M_ESC;
          else if (d == 13) begin m_col = 0; m_cwen = 1; end
          else if (d == 10) begin
            if (m_row < 23) begin m_row++; m_rwen = 1; end else m_scr = 1;
          end
          else if (d == 8) begin if (m_col > 0) begin m_col--; m_cwen = 1; end end
          else if (d == 9) begin m_col = min_i((m_col | 7) + 1, 79); m_cwen = 1; end
          else if (d >= 32 && d <= 126) begin m_pc = d; m_pv = 1; m_mode = M_PRINT; end
        end
        M_ESC: begin
          m_mode = M_IDLE;
          case (d)
            65: if (m_row > 0)  begin m_row--; m_rwen = 1; end
            66: if (m_row < 23) begin m_row++; m_rwen = 1; end
            67: if (m_col < 79) begin m_col++; m_cwen = 1; end
            68: if (m_col > 0)  begin m_col--; m_cwen = 1; end
            72: begin m_row = 0; m_col = 0; m_rwen = 1; m_cwen = 1; end
            74: m_eos = 1;
            75: m_eol = 1;
            89: m_mode = M_YROW;
            default: ;
          endcase
        end
        M_YROW: begin
          if (y < 24) begin m_row = y; m_rwen = 1; end
          m_mode = M_YCOL;
        end
        default: begin
          m_col = min_i(y, 79); m_cwen = 1; m_mode = M_IDLE;
        end
      endcase
    end
  endtask

  // Called 1 time unit after a rising edge: check outputs, drive, advance model, advance clock
  task automatic cyc(input bit rst, input bit v, input logic [7:0] d, input bit pr);
    chk("col_wen", col_wen, m_cwen);
    chk("col_wdata", col_wdata, m_col);
    chk("row_wen", row_wen, m_rwen);
    chk("row_wdata", row_wdata, m_row);
    chk("print_valid", print_valid, m_pv);
    chk("print_char", print_char, m_pc);
    chk("scroll_req", scroll_req, m_scr);
    chk("clr_eol", clr_eol, m_eol);
    chk("clr_eos", clr_eos, m_eos);
    chk("char_ready", char_ready, (m_mode != M_PRINT));
    reset = rst; char_valid = v; char_data = d; print_ready = pr;
    model_step(rst, v, int'(d), pr);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b0, 1'b1, d, 1'b1);
  endtask

  function automatic logic [7:0] pick_byte();
    logic [7:0] tbl [13];
    tbl = '{8'h1B, 8'h0D, 8'h0A, 8'h08, 8'h09, 8'h41, 8'h42, 8'h43,
            8'h44, 8'h48, 8'h4A, 8'h4B, 8'h59};
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return tbl[$urandom_range(0, 12)];
  endfunction

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // Direct cursor addressing
    send(8'h1B); send(8'h59); send(8'h25);
    chk("y_row_wen", row_wen, 1'b1);
    chk("y_row5", row_wdata, 5);
    send(8'h30);
    chk("y_col_wen", col_wen, 1'b1);
    chk("y_col16", col_wdata, 16);

    // Out-of-range Y coordinates
    send(8'h1B); send(8'h48); cyc(0, 0, 0, 0);
    send(8'h1B); send(8'h59); send(8'h7F);
    chk("y_oor_no_rwen", row_wen, 1'b0);
    chk("y_oor_row0", row_wdata, 0);
    send(8'h7F);
    chk("y_col_clamp", col_wdata, 79);

    // Print handshake with 3 wait cycles
    send(8'h1B); send(8'h48);
    send(8'h41);
    for (int i = 0; i < 3; i++) begin
      chk("pw_valid", print_valid, 1'b1);
      chk("pw_char", print_char, 8'h41);
      chk("pw_not_ready", char_ready, 1'b0);
      cyc(0, 1, 8'h0D, 0);
    end
    chk("pw_valid_last", print_valid, 1'b1);
    cyc(0, 0, 8'h00, 1);
    chk("pw_drop", print_valid, 1'b0);
    chk("pw_col1", col_wdata, 1);
    chk("pw_col_wen", col_wen, 1'b1);

    // LF on bottom row scrolls, then ESC A
    send(8'h1B); send(8'h59); send(8'h37); send(8'h20);
    send(8'h0A);
    chk("lf_scroll", scroll_req, 1'b1);
    chk("lf_no_rwen", row_wen, 1'b0);
    send(8'h1B); send(8'h41);
    chk("esc_a_row22", row_wdata, 22);

    // Tabs, backspace at column 0, unknown escape
    send(8'h1B); send(8'h59); send(8'h20); send(8'h23);
    send(8'h09);
    chk("tab_8", col_wdata, 8);
    send(8'h1B); send(8'h59); send(8'h20); send(8'h6E);
    send(8'h09);
    chk("tab_79", col_wdata, 79);
    send(8'h0D); send(8'h08);
    chk("bs_col0", col_wen, 1'b0);
    send(8'h1B); send(8'h51);
    send(8'h42);
    chk("esc_q_print", print_char, 8'h42);
    cyc(0, 0, 0, 0);

    // Reset mid-sequence and mid-print
    send(8'h1B); send(8'h59);
    cyc(1, 1, 8'h30, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 8'h58, 0);
    cyc(1, 0, 0, 0);
    chk("rst_pw_ready", char_ready, 1'b1);
    send(8'h1B); send(8'h48);
    chk("rst_h_both", {row_wen, col_wen}, 2'b11);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), pick_byte(),
          ($urandom_range(0, 2) != 0));
    end
    cyc(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
